// File: rtl/secret_file_loader.sv
// Buffers host message words and serialises them onto the display link bus, followed by a held play command.
// Optional build macro SECRET_LOADER_CMD_CHECK_EN: reject (zero-store) play-command words and flag err.
module secret_file_loader #(
    parameter int WORD_COUNT  = 20,
    parameter int CLK_DIV     = 2,
    parameter int PLAY_CYCLES = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_data,
    input  logic       clear,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] link_out
);

    localparam int FW = $clog2(WORD_COUNT + 1);
    localparam int AW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int PW = (PLAY_CYCLES > 1) ? $clog2(PLAY_CYCLES) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [6:0] PLAY_CMD = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        PLAY
    } state_t;

    state_t        state;
    logic [6:0]    mem [WORD_COUNT];
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_nxt;
    logic [FW-1:0] wr_ptr;
    logic [AW-1:0] word_idx;
    logic [AW-1:0] word_nxt;
    logic [PW-1:0] play_cnt;
    logic [DW-1:0] div_cnt;
    logic          lclk;
    logic [6:0]    data;

    logic          clr_now;
    logic          start_now;
    logic          wr_acc;
    logic          cmd_hit;
    logic [6:0]    store_word;
    logic [6:0]    first_word;
    logic [6:0]    next_word;

    assign link_out = {data, lclk};

    always_comb begin
        clr_now   = (state == IDLE) && clear;
        start_now = (state == IDLE) && start;
        wr_acc    = wr_valid && wr_ready;
`ifdef SECRET_LOADER_CMD_CHECK_EN
        cmd_hit    = (wr_data == PLAY_CMD);
        store_word = cmd_hit ? 7'h00 : wr_data;
`else
        cmd_hit    = 1'b0;
        store_word = wr_data;
`endif
        // clear takes effect before a same-cycle write, so the write lands at slot 0
        wr_ptr   = clr_now ? '0 : fill;
        fill_nxt = wr_ptr + FW'(wr_acc);
        // first word bypasses the array so a write in the start cycle is already visible
        if (wr_acc && (wr_ptr == '0))
            first_word = store_word;
        else if (fill_nxt != '0)
            first_word = mem[0];
        else
            first_word = 7'h00;
        word_nxt  = word_idx + AW'(1);
        next_word = (FW'(word_nxt) < fill) ? mem[word_nxt] : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[AW-1:0]] <= store_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fill     <= '0;
            word_idx <= '0;
            play_cnt <= '0;
            div_cnt  <= '0;
            lclk     <= 1'b0;
            data     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    fill <= fill_nxt;
                    err  <= (err & ~clr_now) | (wr_acc & cmd_hit);
                    if (start_now) begin
                        state    <= SEND;
                        busy     <= 1'b1;
                        word_idx <= '0;
                        div_cnt  <= '0;
                        lclk     <= 1'b0;
                        data     <= first_word;
                        wr_ready <= 1'b0;
                    end else begin
                        wr_ready <= (fill_nxt < FW'(WORD_COUNT));
                    end
                end
                SEND, PLAY: begin
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        lclk    <= ~lclk;
                        // every period boundary is an lclk fall; data only moves here
                        if (lclk) begin
                            if (state == SEND) begin
                                if (word_idx == AW'(WORD_COUNT - 1)) begin
                                    state    <= PLAY;
                                    play_cnt <= '0;
                                    data     <= PLAY_CMD;
                                end else begin
                                    word_idx <= word_nxt;
                                    data     <= next_word;
                                end
                            end else if (play_cnt == PW'(PLAY_CYCLES - 1)) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                data     <= '0;
                                wr_ready <= (fill < FW'(WORD_COUNT));
                            end else begin
                                play_cnt <= play_cnt + PW'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secret_file_loader.sv
// Bench for secret_file_loader: table-driven host-side vectors plus full link-stream checks against a queue-based model.
module tb_secret_file_loader;

    localparam int WC  = 20;
    localparam int CD  = 2;
    localparam int PC  = 160;
    localparam int SEQ = (WC + PC) * 2 * CD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [6:0] wr_data = 7'h00;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] link_out;

    always #5 clk = ~clk;

    secret_file_loader #(
        .WORD_COUNT (WC),
        .CLK_DIV    (CD),
        .PLAY_CYCLES(PC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data (wr_data),
        .clear   (clear),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .link_out(link_out)
    );

`ifdef SECRET_LOADER_CMD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] mq[$];
    logic       err_m = 1'b0;

    typedef struct {
        logic       v;
        logic [6:0] d;
        logic       clr;
        logic       exp_rdy;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] model_store(input logic [6:0] w);
        return (CHK && w == 7'h7F) ? 7'h00 : w;
    endfunction

    task automatic model_write(input logic [6:0] w);
        if (mq.size() < WC) begin
            mq.push_back(model_store(w));
            if (CHK && w == 7'h7F) err_m = 1'b1;
        end
    endtask

    task automatic write_word(input logic [6:0] w);
        check("wr_ready", {31'd0, wr_ready}, {31'd0, mq.size() < WC});
        wr_valid = 1'b1;
        wr_data  = w;
        tick();
        wr_valid = 1'b0;
        model_write(w);
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mq.delete();
        err_m = 1'b0;
    endtask

    // Drives start (optionally with a same-cycle write/clear) and checks the whole link stream.
    task automatic run_seq(input bit with_wr, input logic [6:0] w, input bit with_clr, input bit poke);
        logic [6:0] expq[$];
        logic [6:0] cap[$];
        logic       prev_l;
        logic       el;
        logic [6:0] ed;
        bit         acc;
        acc      = with_wr && (mq.size() < WC);
        start    = 1'b1;
        clear    = with_clr;
        wr_valid = with_wr;
        wr_data  = w;
        tick();
        start    = 1'b0;
        clear    = 1'b0;
        wr_valid = 1'b0;
        if (with_clr) begin
            mq.delete();
            err_m = 1'b0;
        end
        if (acc) model_write(w);
        for (int i = 0; i < WC + PC; i++)
            expq.push_back(i < WC ? (i < mq.size() ? mq[i] : 7'h00) : 7'h7F);
        prev_l = 1'b0;
        for (int c = 1; c <= SEQ; c++) begin
            el = 1'((((c - 1) / CD) % 2));
            ed = expq[(c - 1) / (2 * CD)];
            check("stream", {21'd0, busy, wr_ready, done, link_out},
                  {21'd0, 1'b1, 1'b0, 1'b0, ed, el});
            if (link_out[0] && !prev_l) cap.push_back(link_out[7:1]);
            prev_l = link_out[0];
            if (poke && c == 50) begin
                start = 1'b1; clear = 1'b1; wr_valid = 1'b1; wr_data = 7'h7F;
            end
            if (poke && c == 51) begin
                start = 1'b0; clear = 1'b0; wr_valid = 1'b0;
            end
            tick();
        end
        check("end", {21'd0, busy, wr_ready, done, link_out},
              {21'd0, 1'b0, mq.size() < WC, 1'b1, 8'h00});
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);
        check("rises", cap.size(), WC + PC);
        foreach (cap[i])
            if (i < expq.size()) check("rx_word", {25'd0, cap[i]}, {25'd0, expq[i]});
        check("err", {31'd0, err}, {31'd0, err_m});
    endtask

    initial begin
        vec_t tbl[7];
        int   n;
        int   lhigh;

        // reset state
        repeat (3) tick();
        check("reset_out", {20'd0, busy, done, err, wr_ready, link_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", {31'd0, wr_ready}, 32'd1);

        tbl[0] = '{v:1'b0, d:7'h00, clr:1'b1, exp_rdy:1'b1, exp_err:1'b0};
        tbl[1] = '{v:1'b1, d:7'h05, clr:1'b0, exp_rdy:1'b1, exp_err:1'b0};
        tbl[2] = '{v:1'b1, d:7'h7F, clr:1'b0, exp_rdy:1'b1, exp_err:CHK};
        tbl[3] = '{v:1'b0, d:7'h11, clr:1'b0, exp_rdy:1'b1, exp_err:CHK};
        tbl[4] = '{v:1'b1, d:7'h22, clr:1'b0, exp_rdy:1'b1, exp_err:CHK};
        tbl[5] = '{v:1'b0, d:7'h00, clr:1'b1, exp_rdy:1'b1, exp_err:1'b0};
        tbl[6] = '{v:1'b1, d:7'h33, clr:1'b1, exp_rdy:1'b1, exp_err:1'b0};
        for (int i = 0; i < 7; i++) begin
            check("tbl_ready", {31'd0, wr_ready}, {31'd0, tbl[i].exp_rdy});
            wr_valid = tbl[i].v;
            wr_data  = tbl[i].d;
            clear    = tbl[i].clr;
            tick();
            wr_valid = 1'b0;
            clear    = 1'b0;
            if (tbl[i].clr) begin
                mq.delete();
                err_m = 1'b0;
            end
            if (tbl[i].v) model_write(tbl[i].d);
            check("tbl_err", {31'd0, err}, {31'd0, tbl[i].exp_err});
        end
        run_seq(1'b0, 7'h00, 1'b0, 1'b0);

        // full message, overflow write, busy poke, replay
        do_clear();
        for (int i = 0; i < WC; i++) write_word(7'(7'h41 + i));
        write_word(7'h55);
        run_seq(1'b0, 7'h00, 1'b0, 1'b1);
        run_seq(1'b0, 7'h00, 1'b0, 1'b0);

        // padding with a write in the start cycle
        do_clear();
        write_word(7'h10); write_word(7'h20); write_word(7'h30);
        run_seq(1'b1, 7'h2A, 1'b0, 1'b0);

        // clear and start together send an all-zero message
        run_seq(1'b0, 7'h00, 1'b1, 1'b0);

        // play-command word
        do_clear();
        write_word(7'h7F);
        check("cmd_err", {31'd0, err}, {31'd0, CHK});
        run_seq(1'b0, 7'h00, 1'b0, 1'b0);
        do_clear();
        check("cmd_err_clr", {31'd0, err}, 32'd0);

        // randomized messages
        for (int r = 0; r < 4; r++) begin
            do_clear();
            n = $urandom_range(0, WC + 1);
            for (int i = 0; i < n; i++)
                write_word(($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom));
            run_seq(1'($urandom), 7'($urandom), 1'b0, 1'b0);
        end

        // asynchronous reset in the middle of SEND
        write_word(7'h7E);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid", {21'd0, busy, wr_ready, done, link_out}, 32'd0);
        mq.delete();
        err_m = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("ready_rel", {31'd0, wr_ready}, 32'd1);
        lhigh = 0;
        for (int c = 0; c < 100; c++) begin
            if (link_out != 8'h00) lhigh++;
            tick();
        end
        check("idle_quiet", lhigh, 0);
        check("err_rst", {31'd0, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
